// File: rtl/recebe_movimentos_pkg.sv
// recebe_movimentos_pkg: state codes and protocol constants shared by the move receiver
package recebe_movimentos_pkg;
  typedef enum logic [3:0] {
    OCIOSO       = 4'd0,
    ENVIA        = 4'd1,
    AGUARDA_TX   = 4'd2,
    AGUARDA_BYTE = 4'd3,
    DECODIFICA   = 4'd4,
    GRAVA        = 4'd5,
    FIM          = 4'd6,
    ERRO         = 4'd7
  } estado_t;
  localparam logic [7:0] REQ_BYTE = 8'h53;
  localparam logic [7:0] END_BYTE = 8'h23;
  localparam logic [7:0] MOVE_MIN = 8'h30;
  localparam logic [7:0] MOVE_MAX = 8'h36;
  localparam int DEF_CLKS_PER_BIT = 434;
endpackage

// File: rtl/recebe_movimentos_uart_8n1.sv
// uart_8n1: synchronized 8N1 receiver with glitch-rejecting start detect, plus 8N1 transmitter
module uart_8n1 import recebe_movimentos_pkg::*; #(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_serial,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       rx_valid,
  output logic       rx_ferr,
  output logic [7:0] rx_byte,
  output logic       tx_serial,
  output logic       tx_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_t;
  rx_t rx_st;
  logic [2:0] sync;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [2:0] rx_idx;
  logic [3:0] tx_idx;
  logic [9:0] frame;
  logic tx_busy;
  assign tx_serial = frame[0];
  // sync[1] is the synchronized line, sync[2] its previous value for edge detection
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync     <= 3'b111;
      rx_st    <= R_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      sync     <= {sync[1:0], rx_serial};
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_cnt   <= (rx_st == R_IDLE || rx_cnt == (rx_st == R_START ? HALF : FULL)) ? '0 : rx_cnt + 1'b1;
      case (rx_st)
        R_IDLE:  if (sync[2] && !sync[1]) rx_st <= R_START;
        R_START: if (rx_cnt == HALF) begin
          rx_st  <= sync[1] ? R_IDLE : R_DATA;
          rx_idx <= '0;
        end
        R_DATA:  if (rx_cnt == FULL) begin
          rx_byte <= {sync[1], rx_byte[7:1]};
          rx_idx  <= rx_idx + 1'b1;
          if (rx_idx == 3'd7) rx_st <= R_STOP;
        end
        R_STOP:  if (rx_cnt == FULL) begin
          rx_valid <= sync[1];
          rx_ferr  <= !sync[1];
          rx_st    <= R_IDLE;
        end
        default: rx_st <= R_IDLE;
      endcase
    end
  end
  // frame shifts out LSB first and refills with ones, so the line idles high afterwards
  always_ff @(posedge clock) begin
    if (!reset) begin
      frame   <= '1;
      tx_busy <= 1'b0;
      tx_cnt  <= '0;
      tx_idx  <= '0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (!tx_busy) begin
        if (tx_start) begin
          frame   <= {1'b1, tx_byte, 1'b0};
          tx_busy <= 1'b1;
          tx_cnt  <= '0;
          tx_idx  <= '0;
        end
      end else if (tx_cnt == FULL) begin
        tx_cnt  <= '0;
        frame   <= {1'b1, frame[9:1]};
        tx_idx  <= tx_idx + 1'b1;
        tx_busy <= tx_idx != 4'd9;
        tx_done <= tx_idx == 4'd9;
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/recebe_movimentos.sv
// recebe_movimentos: requests the move list from the host and writes decoded moves into the move RAM
module recebe_movimentos import recebe_movimentos_pkg::*; #(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int MAX_MOVES    = 480
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       rx_serial,
  output logic       saida_serial,
  output logic [8:0] w_addr_movimento,
  output logic       we_movimento,
  output logic [2:0] w_data_movimento,
  output logic [8:0] num_movimentos,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] db_estado
);
  estado_t estado;
  logic [7:0] byte_rx, rx_byte;
  logic rx_valid, rx_ferr, tx_start, tx_done, is_move;
  uart_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clock(clock), .reset(reset), .rx_serial(rx_serial), .tx_start(tx_start), .tx_byte(REQ_BYTE),
    .rx_valid(rx_valid), .rx_ferr(rx_ferr), .rx_byte(rx_byte), .tx_serial(saida_serial), .tx_done(tx_done)
  );
  assign db_estado = estado;
  assign is_move = byte_rx >= MOVE_MIN && byte_rx <= MOVE_MAX;
  // the address counter only moves on writes, so it doubles as the stored move count
  assign num_movimentos = w_addr_movimento;
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado           <= OCIOSO;
      we_movimento     <= 1'b0;
      w_addr_movimento <= '0;
      w_data_movimento <= '0;
      pronto           <= 1'b0;
      erro             <= 1'b0;
      tx_start         <= 1'b0;
      byte_rx          <= '0;
    end else begin
      we_movimento <= 1'b0;
      pronto       <= 1'b0;
      tx_start     <= 1'b0;
      case (estado)
        OCIOSO: if (iniciar) begin
          erro             <= 1'b0;
          w_addr_movimento <= '0;
          tx_start         <= 1'b1;
          estado           <= ENVIA;
        end
        ENVIA:        estado <= AGUARDA_TX;
        AGUARDA_TX:   if (tx_done) estado <= AGUARDA_BYTE;
        AGUARDA_BYTE: if (rx_valid) begin
          byte_rx <= rx_byte;
          estado  <= DECODIFICA;
        end else if (rx_ferr) begin
          erro   <= 1'b1;
          estado <= ERRO;
        end
        DECODIFICA: if (byte_rx == END_BYTE) begin
          pronto <= 1'b1;
          estado <= FIM;
        end else if (is_move && w_addr_movimento != 9'(MAX_MOVES)) begin
          we_movimento     <= 1'b1;
          w_data_movimento <= byte_rx[2:0];
          estado           <= GRAVA;
        end else begin
          erro   <= 1'b1;
          estado <= ERRO;
        end
        GRAVA: begin
          w_addr_movimento <= w_addr_movimento + 1'b1;
          estado           <= AGUARDA_BYTE;
        end
        FIM:     estado <= OCIOSO;
        ERRO:    estado <= OCIOSO;
        default: estado <= OCIOSO;
      endcase
    end
  end
endmodule

// File: tb/tb_recebe_movimentos.sv
// tb_recebe_movimentos: directed sessions checked against a transaction-level model of the move protocol
module tb_recebe_movimentos;
  localparam int CPB = 8;
  localparam int MAXM = 4;
  logic clock = 0, reset = 0, iniciar = 0, rx_serial = 1;
  logic saida_serial, we_movimento, pronto, erro;
  logic [8:0] w_addr_movimento, num_movimentos;
  logic [2:0] w_data_movimento;
  logic [3:0] db_estado;
  int total = 0, bad = 0;
  logic [11:0] exp_w[$];
  bit exp_p, exp_e;
  int exp_n, pronto_seen;
  logic [7:0] sb[$];
  bit ss[$];
  logic [7:0] tx_q[$];
  logic [11:0] cur_w;
  logic [7:0] mon_b;

  recebe_movimentos #(.CLKS_PER_BIT(CPB), .MAX_MOVES(MAXM)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .rx_serial(rx_serial),
    .saida_serial(saida_serial), .w_addr_movimento(w_addr_movimento), .we_movimento(we_movimento),
    .w_data_movimento(w_data_movimento), .num_movimentos(num_movimentos), .pronto(pronto),
    .erro(erro), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // expected writes and outcome derived from the byte list alone
  task automatic model();
    int n;
    bit done;
    logic [7:0] b;
    n = 0; done = 0;
    exp_w.delete(); exp_p = 0; exp_e = 0; exp_n = 0;
    for (int i = 0; i < sb.size() && !done; i++) begin
      b = sb[i];
      if (!ss[i]) begin exp_e = 1; done = 1; end
      else if (b == 8'h23) begin exp_p = 1; exp_n = n; done = 1; end
      else if (b >= 8'h30 && b <= 8'h36 && n < MAXM) begin exp_w.push_back({9'(n), b[2:0]}); n++; end
      else begin exp_e = 1; done = 1; end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rx_serial = 0; cyc(CPB);
    for (int i = 0; i < 8; i++) begin rx_serial = b[i]; cyc(CPB); end
    rx_serial = stop_ok; cyc(CPB);
    rx_serial = 1; cyc(2 * CPB);
  endtask

  task automatic wait_state(input int s, input int lim, input string nm);
    int k;
    k = 0;
    while (db_estado !== 4'(s) && k < lim) begin cyc(1); k++; end
    chk({nm, "_reach_state"}, int'(db_estado), s);
  endtask

  task automatic session(input string nm, input bit glitch, input bit poke);
    pronto_seen = 0; exp_w.delete(); exp_p = 0; exp_e = 0; tx_q.delete();
    iniciar = 1; cyc(1); iniciar = 0;
    chk({nm, "_erro_cleared"}, int'(erro), 0);
    wait_state(3, 300, nm);
    chk({nm, "_req_frames"}, tx_q.size(), 1);
    if (tx_q.size() > 0) chk({nm, "_req_byte"}, int'(tx_q.pop_front()), 'h53);
    if (poke) begin
      iniciar = 1; cyc(1); iniciar = 0; cyc(1);
      chk({nm, "_iniciar_ignored"}, int'(db_estado), 3);
    end
    model();
    if (glitch) begin rx_serial = 0; cyc(2); rx_serial = 1; cyc(12); end
    foreach (sb[i]) send_byte(sb[i], ss[i]);
    cyc(6);
    chk({nm, "_idle"}, int'(db_estado), 0);
    chk({nm, "_erro"}, int'(erro), int'(exp_e));
    chk({nm, "_pronto_count"}, pronto_seen, int'(exp_p));
    chk({nm, "_writes_left"}, exp_w.size(), 0);
  endtask

  // scoreboard: every write and pronto pulse is matched against the model
  initial forever begin
    @(negedge clock);
    if (we_movimento === 1'b1) begin
      chk("write_expected", int'(exp_w.size() > 0), 1);
      if (exp_w.size() > 0) begin
        cur_w = exp_w.pop_front();
        chk("write_addr_data", int'({w_addr_movimento, w_data_movimento}), int'(cur_w));
      end
    end
    if (pronto === 1'b1) begin
      pronto_seen++;
      chk("pronto_expected", int'(exp_p), 1);
      if (exp_p) chk("num_movimentos", int'(num_movimentos), exp_n);
    end
  end

  // decodes every frame the DUT sends to the host
  initial forever begin
    @(negedge saida_serial);
    repeat (CPB / 2) @(posedge clock);
    #1;
    if (saida_serial == 1'b0) begin
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(posedge clock);
        #1;
        mon_b[i] = saida_serial;
      end
      repeat (CPB) @(posedge clock);
      tx_q.push_back(mon_b);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    cyc(3);
    chk("rst_saida", int'(saida_serial), 1);
    chk("rst_we", int'(we_movimento), 0);
    chk("rst_addr", int'(w_addr_movimento), 0);
    chk("rst_data", int'(w_data_movimento), 0);
    chk("rst_num", int'(num_movimentos), 0);
    chk("rst_pronto", int'(pronto), 0);
    chk("rst_erro", int'(erro), 0);
    chk("rst_estado", int'(db_estado), 0);
    reset = 1; cyc(2);

    sb = '{8'h32, 8'h30, 8'h36, 8'h23}; ss = '{1, 1, 1, 1};
    model();
    chk("pin_normal_n", exp_w.size(), 3);
    if (exp_w.size() == 3) begin
      chk("pin_w0", int'(exp_w[0]), 'h002);
      chk("pin_w1", int'(exp_w[1]), 'h008);
      chk("pin_w2", int'(exp_w[2]), 'h016);
    end
    chk("pin_normal_num", exp_n, 3);
    session("normal", 0, 1);

    sb = '{8'h23}; ss = '{1};
    session("empty", 0, 0);

    sb = '{8'h31, 8'h58}; ss = '{1, 1};
    session("invalid", 0, 0);

    sb = '{8'h31, 8'h31, 8'h31, 8'h31, 8'h31}; ss = '{1, 1, 1, 1, 1};
    model();
    chk("pin_overflow_writes", exp_w.size(), 4);
    chk("pin_overflow_err", int'(exp_e), 1);
    session("overflow", 0, 0);

    sb = '{8'h33, 8'h23}; ss = '{1, 1};
    session("glitch", 1, 0);

    sb = '{8'h35, 8'h32}; ss = '{1, 0};
    session("framing", 0, 0);

    rx_serial = 0; cyc(CPB);
    rx_serial = 1; cyc(CPB + 3);
    reset = 0; rx_serial = 1; cyc(1);
    chk("midrst_saida", int'(saida_serial), 1);
    chk("midrst_we", int'(we_movimento), 0);
    chk("midrst_addr", int'(w_addr_movimento), 0);
    chk("midrst_data", int'(w_data_movimento), 0);
    chk("midrst_num", int'(num_movimentos), 0);
    chk("midrst_pronto", int'(pronto), 0);
    chk("midrst_erro", int'(erro), 0);
    chk("midrst_estado", int'(db_estado), 0);
    reset = 1; cyc(4 * CPB);

    sb = '{8'h34, 8'h23}; ss = '{1, 1};
    session("after_reset", 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
